envelope_pwm_shaper: RTL

Downstream stage of the tone player. It takes the player's 1-bit square-wave tone and a note gate, and shapes each note with a 4-bit attack/decay/sustain/release amplitude envelope. It drives the output pins with a tone-gated PWM signal, so consecutive notes are articulated instead of hard-switched. It sits between the player's speaker output and the top-level `io_out` pins.

---
 rtl/envelope_pkg.sv | 15 +
 rtl/envelope_step_timer.sv | 34 +++
 rtl/envelope_pwm_shaper.sv | 117 +++++++++++
 3 files changed

// File: rtl/envelope_pkg.sv
// rtl/envelope_pkg.sv - shared state encoding and level constants for the envelope shaper
package envelope_pkg;

  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

endpackage

// File: rtl/envelope_step_timer.sv
// rtl/envelope_step_timer.sv - prescaler issuing a one-cycle step every div clocks
module envelope_step_timer #(
  parameter int DIV_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic [DIV_W:0] div,
  output logic           step
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W:0]   DIV_ONE = {{DIV_W{1'b0}}, 1'b1};

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  assign step = ({1'b0, div_cnt_q} == (div - DIV_ONE));

  always_comb begin
    div_cnt_d = div_cnt_q + CNT_ONE;
    if (clear || step) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/envelope_pwm_shaper.sv
// rtl/envelope_pwm_shaper.sv - ADSR envelope FSM shaping a square-wave tone into gated PWM
module envelope_pwm_shaper
  import envelope_pkg::*;
#(
  parameter int ATTACK_DIV    = 16,
  parameter int DECAY_DIV     = 64,
  parameter int RELEASE_DIV   = 128,
  parameter int SUSTAIN_LEVEL = 10,
  parameter int DIV_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tone_in,
  input  logic               gate_in,
  output logic               pwm_out,
  output logic               pwm_out_n,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         state
);

  localparam logic [DIV_W:0]   ATTACK_DIV_C  = (DIV_W+1)'(ATTACK_DIV);
  localparam logic [DIV_W:0]   DECAY_DIV_C   = (DIV_W+1)'(DECAY_DIV);
  localparam logic [DIV_W:0]   RELEASE_DIV_C = (DIV_W+1)'(RELEASE_DIV);
  localparam logic [LEVEL_W-1:0] SUSTAIN_C   = LEVEL_W'(SUSTAIN_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE   = {{(LEVEL_W-1){1'b0}}, 1'b1};

  logic               tone_q, gate_q, gate_qq, armed_q;
  logic               rise, step, clear, pwm_on;
  logic               pwm_out_q, pwm_out_n_q;
  logic [LEVEL_W-1:0] level_q, level_d, pwm_cnt_q;
  logic [DIV_W:0]     div_sel;
  env_state_e         state_q, state_d;

  // armed_q blocks a spurious rise when the gate is already high coming out of reset
  assign rise   = gate_q & ~gate_qq & armed_q;
  assign clear  = (state_d != state_q);
  assign pwm_on = (pwm_cnt_q < level_q);

  always_comb begin
    div_sel = ATTACK_DIV_C;
    case (state_q)
      ST_DECAY:   div_sel = DECAY_DIV_C;
      ST_RELEASE: div_sel = RELEASE_DIV_C;
      default:    div_sel = ATTACK_DIV_C;
    endcase
  end

  envelope_step_timer #(
    .DIV_W(DIV_W)
  ) u_step_timer (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .div  (div_sel),
    .step (step)
  );

  always_comb begin
    state_d = state_q;
    if (rise) begin
      state_d = ST_ATTACK;
    end else if (!gate_q && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                             state_q == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else begin
      case (state_q)
        ST_ATTACK:  if (level_q == LEVEL_MAX) state_d = ST_DECAY;
        ST_DECAY:   if (level_q <= SUSTAIN_C) state_d = ST_SUSTAIN;
        ST_RELEASE: if (level_q == '0)        state_d = ST_IDLE;
        default:    state_d = state_q;
      endcase
    end
  end

  // Steps only land when the state is not changing; a retrigger discards a coincident step
  always_comb begin
    level_d = level_q;
    if (step && !rise && !clear) begin
      case (state_q)
        ST_ATTACK:  if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_ONE;
        ST_DECAY,
        ST_RELEASE: if (level_q != '0)        level_d = level_q - LEVEL_ONE;
        default:    level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tone_q      <= 1'b0;
      gate_q      <= 1'b0;
      gate_qq     <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      level_q     <= '0;
      pwm_cnt_q   <= '0;
      pwm_out_q   <= 1'b0;
      pwm_out_n_q <= 1'b1;
    end else begin
      tone_q      <= tone_in;
      gate_q      <= gate_in;
      gate_qq     <= gate_q;
      armed_q     <= armed_q | ~gate_in;
      state_q     <= state_d;
      level_q     <= level_d;
      pwm_cnt_q   <= pwm_cnt_q + LEVEL_ONE;
      pwm_out_q   <= tone_q & pwm_on;
      pwm_out_n_q <= ~(tone_q & pwm_on);
    end
  end

  assign pwm_out   = pwm_out_q;
  assign pwm_out_n = pwm_out_n_q;
  assign level     = level_q;
  assign state     = state_q;

endmodule
